// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD line-fetch block:
//   - fetch_state_t : burst-fetch FSM states (IDLE, REQ, FLUSH, DONE)
//   - pixel_t       : 24-bit RGB pixel as stored in the pixel FIFO
//   - PIX_*_LSB     : colour field positions inside a 32-bit memory word
//   - H_ACT/V_ACT defaults for an 800x480 panel
//   - word_to_pixel : extracts the RGB fields from a memory word
// -----------------------------------------------------------------------------
package lcd_pkg;

  localparam int H_ACT_DEFAULT = 800;
  localparam int V_ACT_DEFAULT = 480;

  localparam int PIX_RED_LSB = 16;
  localparam int PIX_GRN_LSB = 8;
  localparam int PIX_BLU_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

  function automatic pixel_t word_to_pixel(input logic [31:0] word);
    pixel_t p;
    p.red   = word[PIX_RED_LSB +: 8];
    p.green = word[PIX_GRN_LSB +: 8];
    p.blue  = word[PIX_BLU_LSB +: 8];
    return p;
  endfunction

endpackage

// File: rtl/lcd_pixel_fifo.sv
// -----------------------------------------------------------------------------
// lcd_pixel_fifo
// Synchronous show-ahead FIFO: pop_data always presents the oldest entry, and
// pop advances to the next one. A simultaneous push and pop both take effect.
// clear empties the FIFO in one clock and has priority over push/pop.
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   clear            : synchronous flush
//   push, push_data  : write strobe and data
//   pop              : advance read pointer (ignored when empty)
//   pop_data         : head-of-FIFO data
//   empty, level     : status (level = number of stored words)
// -----------------------------------------------------------------------------
module lcd_pixel_fifo #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 24,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (level < LVL_W'(DEPTH));
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is data only; pointers decide validity, so no reset here.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lcd_line_fetch.sv
// -----------------------------------------------------------------------------
// lcd_line_fetch
// Fetches one frame (H_ACT*V_ACT 32-bit words) from a frame buffer with burst
// reads, buffers the pixels in a FIFO and hands one pixel per pixel-clock
// enable to the LCD, one clock after the pop.
// Optional feature: define LCD_FETCH_UNDERFLOW_COUNT_EN to add the saturating
// 16-bit underflow_count output.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   tick                    : pixel-clock enable
//   next_frame, data_enable : frame-start and pixel-needed strobes (on tick)
//   fb_base                 : frame buffer byte address, latched at frame start
//   mem_*                   : burst read master (address/read/burstcount out,
//                             waitrequest/readdata/readdatavalid in)
//   lcd_red/green/blue      : pixel colour
//   lcd_de                  : data_enable aligned to the colour
//   underflow               : sticky "pixel requested while FIFO empty"
//   underflow_count         : (optional) saturating underflow counter
// -----------------------------------------------------------------------------
module lcd_line_fetch
  import lcd_pkg::*;
#(
  parameter int H_ACT      = H_ACT_DEFAULT,
  parameter int V_ACT      = V_ACT_DEFAULT,
  parameter int FIFO_DEPTH = 256,
  parameter int BURST_LEN  = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        next_frame,
  input  logic        data_enable,
  input  logic [31:0] fb_base,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic [5:0]  mem_burstcount,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid,
  output logic [7:0]  lcd_red,
  output logic [7:0]  lcd_green,
  output logic [7:0]  lcd_blue,
  output logic        lcd_de,
  output logic        underflow
`ifdef LCD_FETCH_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0] underflow_count
`endif
);

  localparam int FRAME_WORDS = H_ACT * V_ACT;
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int OUT_W       = LVL_W + 1;

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic [31:0]      words_left;
  logic [OUT_W-1:0] outstanding;
  logic [31:0]      base_hold;
  logic             flush_pend;
  logic             frame_start;
  logic             handshake;
  logic             discard;
  logic             space_ok;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  pixel_t           pix_in;
  pixel_t           fifo_dout;
  pixel_t           pix_p1;
  logic             vld_p1;
  logic             unused_hi;

  function automatic logic [5:0] clip_burst(input logic [31:0] left);
    if (left < 32'(BURST_LEN)) return left[5:0];
    else                       return 6'(BURST_LEN);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign frame_start = tick && next_frame;
  assign handshake   = (state == REQ) && !mem_waitrequest;
  // Words still in flight from the previous frame are dropped: in FLUSH, while
  // a frame start waits for its REQ handshake, and on the strobe itself.
  assign discard     = (state == FLUSH) || flush_pend || frame_start;
  // Reserve room for every word already requested before asking for more.
  assign space_ok    = (32'(fifo_level) + 32'(outstanding) + 32'(BURST_LEN))
                       <= 32'(FIFO_DEPTH);
  assign unused_hi   = &{1'b0, mem_readdata[31:24]};

  assign pix_in    = word_to_pixel(mem_readdata);
  assign fifo_push = mem_readdatavalid && !discard;
  assign fifo_pop  = tick && data_enable && !fifo_empty;

  lcd_pixel_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W ($bits(pixel_t))
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (frame_start),
    .push      (fifo_push),
    .push_data (pix_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (words_left == '0) state_nxt = DONE;
        else if (space_ok)    state_nxt = REQ;
      end
      REQ: begin
        if (!mem_waitrequest) state_nxt = (flush_pend || frame_start) ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (outstanding == '0) state_nxt = IDLE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
    // A stalled REQ must finish its handshake before the flush takes over.
    if (frame_start && !((state == REQ) && mem_waitrequest)) state_nxt = FLUSH;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= DONE;
      mem_read       <= 1'b0;
      mem_address    <= '0;
      mem_burstcount <= '0;
      words_left     <= '0;
      outstanding    <= '0;
      flush_pend     <= 1'b0;
      base_hold      <= '0;
    end else begin
      state       <= state_nxt;
      mem_read    <= (state_nxt == REQ);
      outstanding <= outstanding
                     + (handshake ? OUT_W'(mem_burstcount) : OUT_W'(0))
                     - (mem_readdatavalid ? OUT_W'(1) : OUT_W'(0));
      if ((state == IDLE) && (state_nxt == REQ)) mem_burstcount <= clip_burst(words_left);
      if (handshake) begin
        mem_address <= mem_address + {24'd0, mem_burstcount, 2'b00};
        words_left  <= words_left - 32'(mem_burstcount);
      end
      if (handshake && flush_pend) begin
        mem_address <= base_hold;
        words_left  <= 32'(FRAME_WORDS);
        flush_pend  <= 1'b0;
      end
      if (frame_start) begin
        if ((state == REQ) && mem_waitrequest) begin
          flush_pend <= 1'b1;
          base_hold  <= fb_base;
        end else begin
          mem_address <= fb_base;
          words_left  <= 32'(FRAME_WORDS);
          flush_pend  <= 1'b0;
        end
      end
    end
  end

  // ---- stage p1: colour register, one clock after the pop ----
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_p1    <= '0;
      vld_p1    <= 1'b0;
      underflow <= 1'b0;
    end else if (tick) begin
      vld_p1 <= data_enable;
      pix_p1 <= (data_enable && !fifo_empty) ? fifo_dout : '0;
      if (data_enable && fifo_empty) underflow <= 1'b1;
    end
  end

  assign lcd_red   = pix_p1.red;
  assign lcd_green = pix_p1.green;
  assign lcd_blue  = pix_p1.blue;
  assign lcd_de    = vld_p1;

`ifdef LCD_FETCH_UNDERFLOW_COUNT_EN
  logic [15:0] uf_cnt;

  always_ff @(posedge clock) begin
    if (reset) uf_cnt <= '0;
    else if (tick && data_enable && fifo_empty) uf_cnt <= sat_inc16(uf_cnt);
  end

  assign underflow_count = uf_cnt;
`else
  logic [15:0] unused_sat;
  assign unused_sat = sat_inc16(16'd0);
`endif

endmodule

// File: doc/lcd_line_fetch.md
LCD_LINE_FETCH -- requirements
Module: lcd_line_fetch

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_ACT, 800, visible pixels per line.
  V_ACT, 480, visible lines per frame.
  FIFO_DEPTH, 256, pixel FIFO depth in words (power of two).
  BURST_LEN, 32, words per memory read burst (power of two, at most FIFO_DEPTH/2).
REQ-002 Ports (name, direction, width, meaning), one per line:
  clock  in  1  system clock; single clock domain.
  reset  in  1  synchronous, active-high reset.
  tick  in  1  LCD pixel-clock enable, synchronous with clock.
  next_frame  in  1  one-tick frame-start strobe from the LCD timing generator.
  data_enable  in  1  pixel-needed strobe from the LCD timing generator.
  fb_base  in  32  frame buffer byte address; sampled at next_frame.
  mem_address  out  32  read byte address.
  mem_read  out  1  read request.
  mem_burstcount  out  6  burst length.
  mem_waitrequest  in  1  slave stall.
  mem_readdata  in  32  pixel word; RGB in bits [23:0], red in [23:16].
  mem_readdatavalid  in  1  read data strobe.
  lcd_red, lcd_green, lcd_blue  out  8 each  pixel colour.
  lcd_de  out  1  data_enable delayed to align with colour.
  underflow  out  1  sticky underflow flag.

Function
REQ-003 The block SHALL fetch H_ACT*V_ACT words per frame, starting at the latched fb_base, with the address incrementing by 4 per word.
REQ-004 The FSM SHALL use states IDLE, REQ, FLUSH and DONE.
  IDLE -> REQ when free FIFO space minus outstanding words >= BURST_LEN and words_left > 0.
  REQ holds mem_read=1 with stable address/burstcount until mem_waitrequest=0, then returns to IDLE; address += 4*BURST_LEN; words_left -= BURST_LEN; outstanding += BURST_LEN.
  IDLE -> DONE when words_left == 0.
REQ-005 The final burst SHALL use burstcount = min(BURST_LEN, words_left); words_left SHALL never underflow.
REQ-006 Each mem_readdatavalid SHALL decrement outstanding by 1 and push the word into the FIFO, except in FLUSH, where the word is discarded.
REQ-007 On tick && next_frame, from any state, the block SHALL empty the FIFO, latch fb_base, set words_left = H_ACT*V_ACT, and enter FLUSH.
  If a REQ is pending, it SHALL complete its handshake first and add its words to outstanding.
  FLUSH -> IDLE when outstanding == 0.
REQ-008 On tick && data_enable the block SHALL pop one word.
  On the next clock: lcd_red/green/blue = word fields and lcd_de = 1.
  If the FIFO is empty: colour = 0, underflow is set (sticky until reset), and nothing is popped.
REQ-009 On tick && !data_enable: colour = 0 and lcd_de = 0 on the next clock.
REQ-010 Outputs SHALL hold their values between ticks.
REQ-011 A simultaneous FIFO push and pop SHALL both take effect; the FIFO SHALL never overflow, which is guaranteed by the REQ-004 space check.
REQ-012 Latency from pop to colour SHALL be exactly 1 clock.

Reset
REQ-013 While reset=1, on the clock edge:
  state = DONE; mem_read = 0; mem_address = 0; mem_burstcount = 0.
  FIFO empty; outstanding = 0; words_left = 0.
  Colour = 0; lcd_de = 0; underflow = 0.
REQ-014 Reset asserted mid-burst SHALL abandon the bus transaction immediately; the system resets the memory slave together with this block.
REQ-015 Fetching SHALL begin only at the first next_frame after reset.

Configuration
REQ-016 When LCD_FETCH_UNDERFLOW_COUNT_EN is defined, the block SHALL add output underflow_count [15:0].
  It counts underflow pops, saturates at 16'hFFFF, and clears on reset only.
  Without the macro, the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-017 The FSM state enum, the pixel-word field positions and the H_ACT/V_ACT defaults SHALL live in shared package lcd_pkg.
REQ-018 The FIFO SHALL be sub-module lcd_pixel_fifo: synchronous, show-ahead, with push, pop, empty and level outputs.

Verification
REQ-019 Directed scenarios, one per line (stimulus -> required response):
  Reset, then next_frame with fb_base=0x1000 -> FLUSH then IDLE; first REQ at address 0x1000, burstcount 32.
  Memory model returning word 0x00AABBCC -> after the first tick&&data_enable, next clock shows red=AA, green=BB, blue=CC, lcd_de=1.
  H_ACT=4, V_ACT=2, BURST_LEN=4 -> exactly 2 bursts (addresses base, base+16), then DONE.
  data_enable before any data arrives -> colour 0, underflow=1; with the macro, underflow_count=1.
  next_frame with 32 words outstanding -> those 32 words are discarded; next REQ is at the new fb_base.
  mem_waitrequest held high for 10 clocks -> mem_address and mem_burstcount stay stable; no double issue.
